// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM access controller: FSM state encoding and the
// channel-select width helper.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StWrInc = 3'd2,
        StRead  = 3'd3,
        StRdInc = 3'd4
    } state_e;

    // A single channel still needs one select bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_addr_counter.sv
// Auto-incrementing SRAM address counter with load, saturate/wrap and
// registered EMPTY/FULL flags.
module sram_addr_counter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned WRAP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    input  logic              inc_wr,
    output logic [ADDR_W-1:0] addr,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W-1:0] MaxAddr = '1;

    logic [ADDR_W-1:0] addr_d;
    logic              full_d;

    always_comb begin
        addr_d = addr;
        full_d = full;
        if (load) begin
            addr_d = load_val;
            full_d = 1'b0;
        end else if (inc) begin
            if (addr == MaxAddr) begin
                // Saturating mode parks at the top; only a write marks it full.
                if (WRAP != 0) begin
                    addr_d = '0;
                end else if (inc_wr) begin
                    full_d = 1'b1;
                end
            end else begin
                addr_d = addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            addr  <= addr_d;
            full  <= full_d;
            empty <= (addr_d == '0);
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Arbitrates NUM_CH write requesters and one read port onto a single async
// SRAM; all SRAM strobes and handshake outputs are registered.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WE_CYCLES = 1,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned ARB_RR    = 0,
    parameter int unsigned WRAP      = 0
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [NUM_CH-1:0]        WR_REQ,
    input  logic [NUM_CH*DATA_W-1:0] WR_DATA,
    output logic [NUM_CH-1:0]        WR_ACK,
    input  logic                     RD_REQ,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic                     RD_VALID,
    input  logic                     ADDR_LOAD,
    input  logic [ADDR_W-1:0]        ADDR_LOAD_VAL,
    output logic [ADDR_W-1:0]        ADDR,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVERFLOW,
    output logic                     BUSY,
    output logic [ADDR_W-1:0]        SRAM_A,
    output logic [DATA_W-1:0]        SRAM_DQ_OUT,
    output logic                     SRAM_DQ_OE,
    input  logic [DATA_W-1:0]        SRAM_DQ_IN,
    output logic                     SRAM_WE_n,
    output logic                     SRAM_OE_n
);

    localparam int unsigned SelW = sel_width(NUM_CH);
    localparam int unsigned CntW = 16;

    state_e              state_q, state_d;
    logic [SelW-1:0]     win_q, win_d, rr_q, rr_d, grant;
    logic [CntW-1:0]     cyc_q, cyc_d;
    logic                drop_q, drop_d, load_seen_q, load_seen_d, ovf_d, found;
    logic [DATA_W-1:0]   dq_out_d, rd_data_d;
    logic [ADDR_W-1:0]   sram_a_d;
    logic [NUM_CH-1:0]   ack_d;
    logic                we_n_d, oe_n_d, dq_oe_d, valid_d, inc, inc_wr;
    logic [DATA_W-1:0]   wr_data_arr [NUM_CH];
    int                  idx;

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wr_data_arr[i] = WR_DATA[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starts at rr_q, the channel after the last winner.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < int'(NUM_CH); off++) begin
            idx = off + ((ARB_RR != 0) ? int'(rr_q) : 0);
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (!found && WR_REQ[SelW'(idx)]) begin
                found = 1'b1;
                grant = SelW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        rr_d        = rr_q;
        cyc_d       = cyc_q;
        drop_d      = drop_q;
        dq_out_d    = SRAM_DQ_OUT;
        sram_a_d    = SRAM_A;
        rd_data_d   = RD_DATA;
        ovf_d       = OVERFLOW;
        load_seen_d = load_seen_q | ADDR_LOAD;
        inc         = 1'b0;
        inc_wr      = 1'b0;
        if (ADDR_LOAD && ADDR_LOAD_VAL == '0) ovf_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                load_seen_d = ADDR_LOAD;
                cyc_d       = '0;
                drop_d      = 1'b0;
                if (found) begin
                    win_d    = grant;
                    rr_d     = (int'(grant) == int'(NUM_CH) - 1) ? '0 : SelW'(int'(grant) + 1);
                    dq_out_d = wr_data_arr[grant];
                    sram_a_d = ADDR;
                    if (FULL) begin
                        drop_d  = 1'b1;
                        ovf_d   = 1'b1;
                        state_d = StWrInc;
                    end else begin
                        state_d = StWrite;
                    end
                end else if (RD_REQ) begin
                    sram_a_d = ADDR;
                    state_d  = StRead;
                end
            end
            StWrite: begin
                if (cyc_q == CntW'(WE_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = StWrInc;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StWrInc: begin
                // A load seen during the access replaces the increment.
                inc     = !drop_q && !load_seen_q && !ADDR_LOAD;
                inc_wr  = 1'b1;
                state_d = StIdle;
            end
            StRead: begin
                if (cyc_q == CntW'(RD_CYCLES - 1)) begin
                    rd_data_d = SRAM_DQ_IN;
                    cyc_d     = '0;
                    state_d   = StRdInc;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StRdInc: begin
                inc     = !load_seen_q && !ADDR_LOAD;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        we_n_d  = (state_d != StWrite);
        oe_n_d  = (state_d != StRead);
        dq_oe_d = (state_d == StWrite) || (state_d == StWrInc && !drop_d);
        valid_d = (state_d == StRdInc);
        ack_d   = '0;
        if (state_d == StWrInc) ack_d[win_d] = 1'b1;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            win_q       <= '0;
            rr_q        <= '0;
            cyc_q       <= '0;
            drop_q      <= 1'b0;
            load_seen_q <= 1'b0;
            SRAM_DQ_OUT <= '0;
            SRAM_A      <= '0;
            RD_DATA     <= '0;
            OVERFLOW    <= 1'b0;
            SRAM_WE_n   <= 1'b1;
            SRAM_OE_n   <= 1'b1;
            SRAM_DQ_OE  <= 1'b0;
            WR_ACK      <= '0;
            RD_VALID    <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rr_q        <= rr_d;
            cyc_q       <= cyc_d;
            drop_q      <= drop_d;
            load_seen_q <= load_seen_d;
            SRAM_DQ_OUT <= dq_out_d;
            SRAM_A      <= sram_a_d;
            RD_DATA     <= rd_data_d;
            OVERFLOW    <= ovf_d;
            SRAM_WE_n   <= we_n_d;
            SRAM_OE_n   <= oe_n_d;
            SRAM_DQ_OE  <= dq_oe_d;
            WR_ACK      <= ack_d;
            RD_VALID    <= valid_d;
            BUSY        <= (state_d != StIdle);
        end
    end

    sram_addr_counter #(
        .ADDR_W (ADDR_W),
        .WRAP   (WRAP)
    ) u_addr_counter (
        .clk      (CLOCK),
        .rst      (RESET),
        .load     (ADDR_LOAD),
        .load_val (ADDR_LOAD_VAL),
        .inc      (inc),
        .inc_wr   (inc_wr),
        .addr     (ADDR),
        .empty    (EMPTY),
        .full     (FULL)
    );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: instance a uses defaults, instance b uses
// round-robin arbitration with address wrap.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_req_a = '0, wr_req_b = '0;
    logic [15:0] wr_data = '0;
    logic        rd_req_a = 1'b0;
    logic        rd_req_b;
    logic        addr_load = 1'b0;
    logic [18:0] addr_load_val = '0;
    logic [7:0]  dq_in_a = '0;
    logic [7:0]  dq_in_b;

    logic [1:0]  ack_a, ack_b;
    logic [7:0]  rd_data_a, rd_data_b, dq_out_a, dq_out_b;
    logic        valid_a, valid_b, empty_a, empty_b, full_a, full_b, ovf_a, ovf_b;
    logic        busy_a, busy_b, dq_oe_a, dq_oe_b, we_n_a, we_n_b, oe_n_a, oe_n_b;
    logic [18:0] addr_a, addr_b, sram_a_a, sram_a_b;

    assign rd_req_b = 1'b0;
    assign dq_in_b  = 8'h00;

    always #5 clk = ~clk;

    sram_access_ctrl dut_a (
        .CLOCK(clk), .RESET(rst), .WR_REQ(wr_req_a), .WR_DATA(wr_data), .WR_ACK(ack_a),
        .RD_REQ(rd_req_a), .RD_DATA(rd_data_a), .RD_VALID(valid_a), .ADDR_LOAD(addr_load),
        .ADDR_LOAD_VAL(addr_load_val), .ADDR(addr_a), .EMPTY(empty_a), .FULL(full_a),
        .OVERFLOW(ovf_a), .BUSY(busy_a), .SRAM_A(sram_a_a), .SRAM_DQ_OUT(dq_out_a),
        .SRAM_DQ_OE(dq_oe_a), .SRAM_DQ_IN(dq_in_a), .SRAM_WE_n(we_n_a), .SRAM_OE_n(oe_n_a)
    );

    sram_access_ctrl #(.ARB_RR(1), .WRAP(1)) dut_b (
        .CLOCK(clk), .RESET(rst), .WR_REQ(wr_req_b), .WR_DATA(wr_data), .WR_ACK(ack_b),
        .RD_REQ(rd_req_b), .RD_DATA(rd_data_b), .RD_VALID(valid_b), .ADDR_LOAD(addr_load),
        .ADDR_LOAD_VAL(addr_load_val), .ADDR(addr_b), .EMPTY(empty_b), .FULL(full_b),
        .OVERFLOW(ovf_b), .BUSY(busy_b), .SRAM_A(sram_a_b), .SRAM_DQ_OUT(dq_out_b),
        .SRAM_DQ_OE(dq_oe_b), .SRAM_DQ_IN(dq_in_b), .SRAM_WE_n(we_n_b), .SRAM_OE_n(oe_n_b)
    );

    // SRAM model for instance a plus free-running strobe/handshake counters.
    bit [7:0] mem_a [int unsigned];
    int we_cnt_a = 0, we_cnt_b = 0, oe_cnt_a = 0, ack_cnt_a = 0, viol = 0;

    always @(negedge clk) begin
        if (!we_n_a && dq_oe_a) mem_a[int'(sram_a_a)] = dq_out_a;
        dq_in_a = !oe_n_a ? mem_a[int'(sram_a_a)] : 8'h00;
        if (!we_n_a) we_cnt_a++;
        if (!we_n_b) we_cnt_b++;
        if (!oe_n_a) oe_cnt_a++;
        if (ack_a != 2'b00) ack_cnt_a++;
        if ((!we_n_a && !oe_n_a) || (dq_oe_a && !oe_n_a)) viol++;
        if ((!we_n_b && !oe_n_b) || (dq_oe_b && !oe_n_b)) viol++;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int          inst;
        logic        do_load;
        logic [18:0] load_val;
        int          ch;
        logic [7:0]  data;
        int          exp_lat;
        logic [18:0] exp_addr;
        logic        exp_full;
        logic        exp_ovf;
        int          exp_we;
    } vec_t;

    vec_t vecs [11];

    task automatic do_write(input vec_t v);
        int lat, we0, weN;
        logic [1:0] ackv;
        lat = 0;
        ackv = '0;
        @(negedge clk);
        if (v.do_load) begin
            addr_load = 1'b1;
            addr_load_val = v.load_val;
            @(negedge clk);
            addr_load = 1'b0;
        end
        we0 = (v.inst == 0) ? we_cnt_a : we_cnt_b;
        if (v.ch == 0) wr_data[7:0] = v.data;
        else wr_data[15:8] = v.data;
        if (v.inst == 0) wr_req_a = 2'b01 << v.ch;
        else wr_req_b = 2'b01 << v.ch;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ackv = (v.inst == 0) ? ack_a : ack_b;
            if (ackv != 2'b00) begin
                lat = k;
                break;
            end
        end
        wr_req_a = '0;
        wr_req_b = '0;
        check("wr_ack_latency", 32'(lat), 32'(v.exp_lat));
        check("wr_ack_channel", 32'(ackv), 32'(2'b01 << v.ch));
        @(negedge clk);
        weN = (v.inst == 0) ? we_cnt_a : we_cnt_b;
        if (v.inst == 0) begin
            check("addr", 32'(addr_a), 32'(v.exp_addr));
            check("full", 32'(full_a), 32'(v.exp_full));
            check("overflow", 32'(ovf_a), 32'(v.exp_ovf));
            check("empty", 32'(empty_a), 32'(v.exp_addr == 19'h0));
            check("busy_idle", 32'(busy_a), 32'(0));
        end else begin
            check("addr_b", 32'(addr_b), 32'(v.exp_addr));
            check("full_b", 32'(full_b), 32'(v.exp_full));
            check("empty_b", 32'(empty_b), 32'(v.exp_addr == 19'h0));
        end
        check("we_pulse_cycles", 32'(weN - we0), 32'(v.exp_we));
    endtask

    initial begin
        logic [1:0] seq_a [4];
        logic [1:0] seq_b [4];
        int t_a [4];
        int na, nb, lat, oe0, ack0;

        //                inst load  load_val  ch data   lat exp_addr  full ovf  we
        vecs[0]  = '{0, 1'b0, 19'h00000, 0, 8'hA5, 2, 19'h00001, 1'b0, 1'b0, 1};
        vecs[1]  = '{0, 1'b0, 19'h00000, 1, 8'h5A, 2, 19'h00002, 1'b0, 1'b0, 1};
        vecs[2]  = '{0, 1'b1, 19'h00100, 0, 8'h3C, 2, 19'h00101, 1'b0, 1'b0, 1};
        vecs[3]  = '{0, 1'b1, 19'h7FFFE, 0, 8'h11, 2, 19'h7FFFF, 1'b0, 1'b0, 1};
        vecs[4]  = '{0, 1'b0, 19'h00000, 1, 8'h22, 2, 19'h7FFFF, 1'b1, 1'b0, 1};
        vecs[5]  = '{0, 1'b0, 19'h00000, 0, 8'h33, 1, 19'h7FFFF, 1'b1, 1'b1, 0};
        vecs[6]  = '{0, 1'b1, 19'h00010, 0, 8'h44, 2, 19'h00011, 1'b0, 1'b1, 1};
        vecs[7]  = '{0, 1'b1, 19'h00000, 1, 8'h55, 2, 19'h00001, 1'b0, 1'b0, 1};
        vecs[8]  = '{1, 1'b1, 19'h7FFFE, 0, 8'h01, 2, 19'h7FFFF, 1'b0, 1'b0, 1};
        vecs[9]  = '{1, 1'b0, 19'h00000, 1, 8'h02, 2, 19'h00000, 1'b0, 1'b0, 1};
        vecs[10] = '{1, 1'b0, 19'h00000, 0, 8'h03, 2, 19'h00001, 1'b0, 1'b0, 1};

        do_reset();
        check("rst_addr", 32'(addr_a), 32'(0));
        check("rst_empty", 32'(empty_a), 32'(1));
        check("rst_flags", 32'({full_a, ovf_a, busy_a, valid_a, ack_a}), 32'(0));
        check("rst_strobes", 32'({we_n_a, oe_n_a, dq_oe_a}), 32'(3'b110));
        check("rst_rd_data", 32'(rd_data_a), 32'(0));

        for (int i = 0; i < 11; i++) do_write(vecs[i]);
        check("mem_0x000", 32'(mem_a[0]), 32'(8'h55));
        check("mem_0x100", 32'(mem_a[32'h100]), 32'(8'h3C));
        check("mem_top", 32'(mem_a[32'h7FFFF]), 32'(8'h22));

        // Read back 0x3C from 0x100.
        @(negedge clk);
        addr_load = 1'b1;
        addr_load_val = 19'h00100;
        @(negedge clk);
        addr_load = 1'b0;
        oe0 = oe_cnt_a;
        rd_req_a = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (valid_a) begin
                lat = k;
                break;
            end
        end
        rd_req_a = 1'b0;
        check("rd_valid_latency", 32'(lat), 32'(3));
        check("rd_data", 32'(rd_data_a), 32'(8'h3C));
        @(negedge clk);
        check("rd_valid_pulse", 32'(valid_a), 32'(0));
        check("rd_addr_inc", 32'(addr_a), 32'(19'h00101));
        check("rd_oe_cycles", 32'(oe_cnt_a - oe0), 32'(2));
        repeat (2) @(negedge clk);
        check("rd_data_hold", 32'(rd_data_a), 32'(8'h3C));

        // Both channels held: fixed priority starves ch1, round-robin alternates.
        do_reset();
        na = 0;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            seq_a[i] = '0;
            seq_b[i] = '0;
            t_a[i] = 0;
        end
        wr_data = 16'hB7A6;
        wr_req_a = 2'b11;
        wr_req_b = 2'b11;
        for (int k = 1; k <= 40 && (na < 4 || nb < 4); k++) begin
            @(negedge clk);
            if (ack_a != 2'b00 && na < 4) begin
                seq_a[na] = ack_a;
                t_a[na] = k;
                na++;
            end
            if (ack_b != 2'b00 && nb < 4) begin
                seq_b[nb] = ack_b;
                nb++;
            end
        end
        wr_req_a = '0;
        wr_req_b = '0;
        for (int i = 0; i < 4; i++) begin
            check("fixed_prio_ack", 32'(seq_a[i]), 32'(2'b01));
            check("rr_ack", 32'(seq_b[i]), 32'((i % 2 == 1) ? 2'b10 : 2'b01));
        end
        check("fixed_prio_period", 32'(t_a[3] - t_a[0]), 32'(9));
        repeat (4) @(negedge clk);

        // Reset in the middle of a write.
        do_reset();
        ack0 = ack_cnt_a;
        wr_data = 16'h0099;
        wr_req_a = 2'b01;
        @(negedge clk);
        check("write_we_low", 32'(we_n_a), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("rst_async_we_n", 32'(we_n_a), 32'(1));
        check("rst_async_dq_oe", 32'(dq_oe_a), 32'(0));
        wr_req_a = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_ack", 32'(ack_cnt_a - ack0), 32'(0));
        check("rst_mid_addr", 32'(addr_a), 32'(0));

        // ADDR_LOAD while a write to 0x10 is in flight.
        addr_load = 1'b1;
        addr_load_val = 19'h00010;
        @(negedge clk);
        addr_load = 1'b0;
        wr_data = 16'h0077;
        wr_req_a = 2'b01;
        @(negedge clk);
        addr_load = 1'b1;
        addr_load_val = 19'h00040;
        @(negedge clk);
        addr_load = 1'b0;
        check("load_mid_ack", 32'(ack_a), 32'(2'b01));
        wr_req_a = '0;
        @(negedge clk);
        check("load_mid_addr", 32'(addr_a), 32'(19'h00040));
        check("load_mid_mem", 32'(mem_a[32'h10]), 32'(8'h77));

        check("strobe_exclusion", 32'(viol), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
